carregador_de_programa: RTL

Serial-byte program loader and writer side of the instruction memory.
- Receives a word count followed by instruction bytes from a byte source (UART RX or testbench).
- Assembles the bytes into 32-bit big-endian words and issues single-cycle writes into the instruction memory's write port.
- While loading, asserts ocupado. Top level routes ocupado into the processor's reset, so the CPU fetches 0x00000000 until the load completes.

---
 rtl/carregador_de_programa.sv | 104 ++++++++++
 1 files changed

// File: rtl/carregador_de_programa.sv
// Serial-byte program loader: takes a word-count header and then big-endian instruction
// bytes, and issues one single-cycle write per assembled 32-bit word into instruction memory.
module carregador_de_programa #(
  parameter int NUM_PALAVRAS = 51,
  parameter int LARGURA_CONT = 6
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    iniciar,
  input  logic                    byte_valido,
  input  logic [7:0]              byte_dado,
  output logic                    pronto,
  output logic                    escrita_habilita,
  output logic [31:0]             endereco_escrita,
  output logic [31:0]             dado_escrita,
  output logic                    ocupado,
  output logic                    concluido,
  output logic                    erro,
  output logic [LARGURA_CONT-1:0] palavras_carregadas
);

  localparam logic [2:0] OCIOSO    = 3'd0;
  localparam logic [2:0] CABECALHO = 3'd1;
  localparam logic [2:0] BYTES     = 3'd2;
  localparam logic [2:0] ESCRITA   = 3'd3;
  localparam logic [2:0] CONCLUIDO = 3'd4;
  localparam logic [2:0] ERRO      = 3'd5;

  logic [2:0]              estado, prox_estado;
  logic [7:0]              total;
  logic [1:0]              indice;
  // Only the first three bytes of a word need storing; the fourth goes straight to dado_escrita.
  logic [23:0]             palavra;
  logic                    transf;
  logic                    cabecalho_ok;
  logic                    ultima;
  logic [LARGURA_CONT-1:0] cont_inc;

  assign transf       = byte_valido && pronto;
  assign cont_inc     = palavras_carregadas + LARGURA_CONT'(1);
  assign cabecalho_ok = (byte_dado != 8'd0) && (int'(byte_dado) <= NUM_PALAVRAS);
  assign ultima       = (int'(cont_inc) == int'(total));

  assign pronto           = (estado == CABECALHO) || (estado == BYTES);
  assign ocupado          = pronto || (estado == ESCRITA);
  assign escrita_habilita = (estado == ESCRITA);
  assign concluido        = (estado == CONCLUIDO);
  assign erro             = (estado == ERRO);

  always_comb begin
    prox_estado = estado;
    case (estado)
      OCIOSO, CONCLUIDO, ERRO:
        if (iniciar) prox_estado = CABECALHO;
      CABECALHO:
        if (transf) prox_estado = cabecalho_ok ? BYTES : ERRO;
      BYTES:
        if (transf && (indice == 2'd3)) prox_estado = ESCRITA;
      ESCRITA:
        prox_estado = ultima ? CONCLUIDO : BYTES;
      default:
        prox_estado = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado              <= OCIOSO;
      total               <= '0;
      indice              <= '0;
      palavra             <= '0;
      palavras_carregadas <= '0;
      endereco_escrita    <= '0;
      dado_escrita        <= '0;
    end else begin
      estado <= prox_estado;
      case (estado)
        OCIOSO, CONCLUIDO, ERRO:
          if (iniciar) palavras_carregadas <= '0;
        CABECALHO:
          if (transf) begin
            total  <= byte_dado;
            indice <= '0;
          end
        BYTES:
          if (transf) begin
            palavra <= {palavra[15:0], byte_dado};
            indice  <= indice + 2'd1;
            // Write bus is loaded on the 4th byte so it is stable for the whole strobe and holds afterwards.
            if (indice == 2'd3) begin
              dado_escrita     <= {palavra, byte_dado};
              endereco_escrita <= {{(30-LARGURA_CONT){1'b0}}, palavras_carregadas, 2'b00};
            end
          end
        ESCRITA: begin
          palavras_carregadas <= cont_inc;
          indice              <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
